// File: rtl/sprite_blitter_pkg.sv
// Shared types and defaults for the sprite blitter: FSM states, frame size
// defaults, palette width and the pixel gating helper.
package sprite_blitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        DRAIN = 2'd2
    } blit_state_t;

    localparam int FRAME_W_DEFAULT = 1280;
    localparam int FRAME_H_DEFAULT = 300;
    localparam int PAL_WIDTH       = 3;

    // Clipped or transparent pixels become a no-write (palette 0).
    function automatic logic [PAL_WIDTH-1:0] gate_pixel(
        input logic                 clip,
        input logic [PAL_WIDTH-1:0] data
    );
        return clip ? '0 : data;
    endfunction

endpackage

// File: rtl/sprite_blitter_counter.sv
// Column/row stepping over a sprite with a running ROM address and a
// last-pixel flag; loaded on command acceptance, advanced once per draw cycle.
module blit_counter #(
    parameter int SIZE_WIDTH     = 8,
    parameter int ROM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load,
    input  logic                      i_step,
    input  logic [SIZE_WIDTH-1:0]     i_w,
    input  logic [SIZE_WIDTH-1:0]     i_h,
    input  logic [ROM_ADDR_WIDTH-1:0] i_base,
    output logic [SIZE_WIDTH-1:0]     o_col,
    output logic [SIZE_WIDTH-1:0]     o_row,
    output logic [ROM_ADDR_WIDTH-1:0] o_addr,
    output logic                      o_last
);

    logic [SIZE_WIDTH-1:0]     r_col;
    logic [SIZE_WIDTH-1:0]     r_row;
    logic [SIZE_WIDTH-1:0]     r_w;
    logic [SIZE_WIDTH-1:0]     r_h;
    logic [ROM_ADDR_WIDTH-1:0] r_addr;
    logic                      w_col_end;

    assign w_col_end = (r_col == r_w - SIZE_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_w    <= '0;
            r_h    <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_col  <= '0;
            r_row  <= '0;
            r_w    <= i_w;
            r_h    <= i_h;
            r_addr <= i_base;
        end else if (i_step) begin
            // Sprite is packed row-major, so the address simply runs on.
            r_addr <= r_addr + ROM_ADDR_WIDTH'(1);
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + SIZE_WIDTH'(1);
            end else begin
                r_col <= r_col + SIZE_WIDTH'(1);
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_addr = r_addr;
    assign o_last = w_col_end && (r_row == r_h - SIZE_WIDTH'(1));

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: reads a sprite from ROM one pixel per cycle and emits
// clipped frame-buffer pixel writes two cycles after each ROM read.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int COOR_WIDTH     = 12,
    parameter int FRAME_W        = FRAME_W_DEFAULT,
    parameter int FRAME_H        = FRAME_H_DEFAULT,
    parameter int ROM_ADDR_WIDTH = 16,
    parameter int SIZE_WIDTH     = 8
) (
    input  logic                      clk_33m,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [COOR_WIDTH-1:0]     cmd_x,
    input  logic [COOR_WIDTH-1:0]     cmd_y,
    input  logic [SIZE_WIDTH-1:0]     cmd_w,
    input  logic [SIZE_WIDTH-1:0]     cmd_h,
    input  logic [ROM_ADDR_WIDTH-1:0] cmd_base,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [PAL_WIDTH-1:0]      rom_data,
    output logic [COOR_WIDTH-1:0]     write_x,
    output logic [COOR_WIDTH-1:0]     write_y,
    output logic [PAL_WIDTH-1:0]      write_palette,
    output logic                      busy
);

    localparam int SUM_W = COOR_WIDTH + 1;
    localparam logic [SUM_W-1:0] LP_FRAME_W = SUM_W'(FRAME_W);
    localparam logic [SUM_W-1:0] LP_FRAME_H = SUM_W'(FRAME_H);

    blit_state_t               r_state;
    logic [COOR_WIDTH-1:0]     r_x;
    logic [COOR_WIDTH-1:0]     r_y;
    logic                      r_vld_p0;
    logic [SUM_W-1:0]          r_sx_p0;
    logic [SUM_W-1:0]          r_sy_p0;
    logic                      r_vld_p1;
    logic [COOR_WIDTH-1:0]     r_wx_p1;
    logic [COOR_WIDTH-1:0]     r_wy_p1;
    logic [PAL_WIDTH-1:0]      r_pal_p1;

    logic                      w_cmd_ready;
    logic                      w_start;
    logic                      w_step;
    logic                      w_last;
    logic                      w_clip;
    logic [SIZE_WIDTH-1:0]     w_col;
    logic [SIZE_WIDTH-1:0]     w_row;
    logic [ROM_ADDR_WIDTH-1:0] w_addr;
    logic [SUM_W-1:0]          w_sum_x;
    logic [SUM_W-1:0]          w_sum_y;

    assign w_cmd_ready = (r_state == IDLE) && !frame_start && !rst;
    // Zero-sized commands are consumed here without ever leaving IDLE.
    assign w_start     = cmd_valid && w_cmd_ready && (cmd_w != '0) && (cmd_h != '0);
    assign w_step      = (r_state == DRAW) && !frame_start;

    blit_counter #(
        .SIZE_WIDTH     (SIZE_WIDTH),
        .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH)
    ) u_counter (
        .clk    (clk_33m),
        .rst    (rst),
        .i_load (w_start),
        .i_step (w_step),
        .i_w    (cmd_w),
        .i_h    (cmd_h),
        .i_base (cmd_base),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (frame_start) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start) r_state <= DRAW;
                DRAW:    if (w_last)  r_state <= DRAIN;
                DRAIN:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_start) begin
            r_x <= cmd_x;
            r_y <= cmd_y;
        end
    end

    // Sums carry one extra bit so off-frame pixels clip instead of wrapping.
    assign w_sum_x = {1'b0, r_x} + SUM_W'(w_col);
    assign w_sum_y = {1'b0, r_y} + SUM_W'(w_row);

    // p0: coordinates of the ROM read in flight
    always_ff @(posedge clk_33m) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_step;
        end
        r_sx_p0 <= w_sum_x;
        r_sy_p0 <= w_sum_y;
    end

    assign w_clip = (r_sx_p0 >= LP_FRAME_W) || (r_sy_p0 >= LP_FRAME_H);

    // p1: registered pixel write, ROM data arrives alongside p0
    always_ff @(posedge clk_33m) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_pal_p1 <= '0;
            r_wx_p1  <= '0;
            r_wy_p1  <= '0;
        end else if (frame_start) begin
            r_vld_p1 <= 1'b0;
            r_pal_p1 <= '0;
        end else begin
            r_vld_p1 <= r_vld_p0;
            if (r_vld_p0) begin
                r_wx_p1  <= r_sx_p0[COOR_WIDTH-1:0];
                r_wy_p1  <= r_sy_p0[COOR_WIDTH-1:0];
                r_pal_p1 <= gate_pixel(w_clip, rom_data);
            end else begin
                r_pal_p1 <= '0;
            end
        end
    end

    assign cmd_ready     = w_cmd_ready;
    assign rom_addr      = w_addr;
    assign write_x       = r_wx_p1;
    assign write_y       = r_wy_p1;
    assign write_palette = r_pal_p1;
    assign busy          = (r_state != IDLE) || r_vld_p0 || r_vld_p1;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: expected writes are queued when a
// command is issued and popped whenever the DUT emits a non-zero pixel write.
module tb_sprite_blitter;

    logic        clk_33m = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_x = '0;
    logic [11:0] cmd_y = '0;
    logic [7:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [15:0] cmd_base = '0;
    logic [15:0] rom_addr;
    logic [2:0]  rom_data = '0;
    logic [11:0] write_x;
    logic [11:0] write_y;
    logic [2:0]  write_palette;
    logic        busy;

    logic [2:0]  mem [0:65535];

    typedef struct {
        int x;
        int y;
        int p;
    } wr_t;
    wr_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;
    bit mon_en = 1'b0;

    sprite_blitter dut (
        .clk_33m       (clk_33m),
        .rst           (rst),
        .frame_start   (frame_start),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .cmd_w         (cmd_w),
        .cmd_h         (cmd_h),
        .cmd_base      (cmd_base),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .write_x       (write_x),
        .write_y       (write_y),
        .write_palette (write_palette),
        .busy          (busy)
    );

    always #5 clk_33m = ~clk_33m;

    // ROM model: one cycle of read latency
    always @(posedge clk_33m) rom_data <= mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_33m) begin
        if (mon_en && write_palette !== 3'd0) begin
            wr_t e;
            n_wr++;
            if (sb.size() == 0) begin
                chk("spurious_write", {29'd0, write_palette}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_x", {20'd0, write_x}, e.x);
                chk("wr_y", {20'd0, write_y}, e.y);
                chk("wr_pal", {29'd0, write_palette}, e.p);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_33m);
            #1;
        end
    endtask

    // Queue the first npix effective writes of a sprite.
    task automatic push_sprite(input int x, input int y, input int w, input int base, input int npix);
        for (int i = 0; i < npix; i++) begin
            int col;
            int row;
            int p;
            col = i % w;
            row = i / w;
            p   = int'(mem[base + i]);
            if (x + col < 1280 && y + row < 300 && p != 0)
                sb.push_back('{x + col, y + row, p});
        end
    endtask

    // Returns with the acceptance edge just passed (first DRAW cycle).
    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input int base, output int waited);
        cmd_x     = 12'(x);
        cmd_y     = 12'(y);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_base  = 16'(base);
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            step(1);
            waited++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        int w0;
        for (int i = 0; i < 65536; i++) mem[i] = 3'd0;
        for (int i = 0; i < 4; i++) mem[100 + i] = 3'(i + 1);
        for (int i = 0; i < 3; i++) mem[200 + i] = 3'd5;
        mem[300] = 3'd0; mem[301] = 3'd7; mem[302] = 3'd0; mem[303] = 3'd7;
        mem[400] = 3'd6;
        for (int i = 0; i < 256; i++) mem[1000 + i] = 3'((i % 7) + 1);
        for (int i = 0; i < 32; i++) mem[2000 + i] = 3'd2;
        mem[2100] = 3'd3; mem[2101] = 3'd6;

        // Reset state
        step(3);
        mon_en = 1'b1;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pal", {29'd0, write_palette}, 32'd0);
        chk("rst_wx", {20'd0, write_x}, 32'd0);
        chk("rst_addr", {16'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Basic 2x2 sprite with exact latency
        push_sprite(10, 20, 2, 100, 4);
        send_cmd(10, 20, 2, 2, 100, wt);
        chk("t25_addr0", {16'd0, rom_addr}, 32'd100);
        chk("t25_busy", {31'd0, busy}, 32'd1);
        chk("t25_ready_lo", {31'd0, cmd_ready}, 32'd0);
        step(1);
        chk("t25_addr1", {16'd0, rom_addr}, 32'd101);
        chk("t25_pal_early", {29'd0, write_palette}, 32'd0);
        step(1);
        chk("t25_addr2", {16'd0, rom_addr}, 32'd102);
        chk("t25_pal0", {29'd0, write_palette}, 32'd1);
        step(1);
        chk("t25_addr3", {16'd0, rom_addr}, 32'd103);
        chk("t25_pal1", {29'd0, write_palette}, 32'd2);
        step(1);
        chk("t25_pal2", {29'd0, write_palette}, 32'd3);
        chk("t25_drain_ready", {31'd0, cmd_ready}, 32'd0);
        step(1);
        chk("t25_pal3", {29'd0, write_palette}, 32'd4);
        chk("t25_ready_hi", {31'd0, cmd_ready}, 32'd1);
        step(1);
        chk("t25_pal_end", {29'd0, write_palette}, 32'd0);
        chk("t25_busy_lo", {31'd0, busy}, 32'd0);
        chk("t25_hold_x", {20'd0, write_x}, 32'd11);

        // Right-edge clipping
        push_sprite(1279, 0, 3, 200, 3);
        send_cmd(1279, 0, 3, 1, 200, wt);
        step(2);
        chk("t26_pal", {29'd0, write_palette}, 32'd5);
        chk("t26_x", {20'd0, write_x}, 32'd1279);
        step(1);
        chk("t26_clip1", {29'd0, write_palette}, 32'd0);
        step(1);
        chk("t26_clip2", {29'd0, write_palette}, 32'd0);
        step(2);

        // Transparency
        w0 = n_wr;
        push_sprite(50, 60, 4, 300, 4);
        send_cmd(50, 60, 4, 1, 300, wt);
        step(8);
        chk("t27_writes", n_wr - w0, 32'd2);

        // Abort by frame_start in the 3rd DRAW cycle of a 16x16 sprite
        w0 = n_wr;
        push_sprite(100, 100, 16, 1000, 1);
        send_cmd(100, 100, 16, 16, 1000, wt);
        step(2);
        frame_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t28_pal_zero", {29'd0, write_palette}, 32'd0);
            chk("t28_ready_lo", {31'd0, cmd_ready}, 32'd0);
        end
        chk("t28_busy_lo", {31'd0, busy}, 32'd0);
        frame_start = 1'b0;
        #1;
        chk("t28_ready_hi", {31'd0, cmd_ready}, 32'd1);
        step(4);
        chk("t28_writes", n_wr - w0, 32'd1);

        // Zero-width command, then back-to-back acceptance
        w0 = n_wr;
        send_cmd(5, 5, 0, 5, 500, wt);
        chk("t29_busy", {31'd0, busy}, 32'd0);
        chk("t29_ready", {31'd0, cmd_ready}, 32'd1);
        push_sprite(5, 5, 1, 400, 1);
        send_cmd(5, 5, 1, 1, 400, wt);
        chk("t29_wait", wt, 32'd0);
        step(5);
        chk("t29_writes", n_wr - w0, 32'd1);

        // Reset mid-sprite
        w0 = n_wr;
        send_cmd(40, 40, 8, 4, 2000, wt);
        step(1);
        rst = 1'b1;
        step(1);
        chk("t30_ready", {31'd0, cmd_ready}, 32'd0);
        chk("t30_busy", {31'd0, busy}, 32'd0);
        chk("t30_pal", {29'd0, write_palette}, 32'd0);
        chk("t30_wx", {20'd0, write_x}, 32'd0);
        chk("t30_wy", {20'd0, write_y}, 32'd0);
        chk("t30_addr", {16'd0, rom_addr}, 32'd0);
        step(1);
        rst = 1'b0;
        #1;
        chk("t30_ready_hi", {31'd0, cmd_ready}, 32'd1);
        step(6);
        chk("t30_no_stale", n_wr - w0, 32'd0);
        push_sprite(30, 40, 2, 2100, 2);
        send_cmd(30, 40, 2, 1, 2100, wt);
        step(6);
        chk("t30_new_writes", n_wr - w0, 32'd2);

        step(3);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameters (name, default, meaning): COOR_WIDTH, 12, coordinate width.
REQ-002 SHALL have parameters: FRAME_W, 1280, writable frame width in pixels; FRAME_H, 300, writable frame height.
REQ-003 SHALL have parameters: ROM_ADDR_WIDTH, 16, sprite ROM address width; SIZE_WIDTH, 8, sprite width/height field width.
REQ-004 SHALL have ports in this order (name, direction, width, meaning):
- clk_33m  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  level input, driven by the frame buffer's rst_screen_33m; high marks the buffer swap window.
- cmd_valid  in  1  draw command offered.
- cmd_ready  out  1  command accepted when both are high.
- cmd_x, cmd_y  in  COOR_WIDTH each  sprite top-left corner.
- cmd_w, cmd_h  in  SIZE_WIDTH each  sprite size in pixels.
- cmd_base  in  ROM_ADDR_WIDTH  ROM address of sprite pixel (0,0); row-major, packed, cmd_w pixels per row.
- rom_addr  out  ROM_ADDR_WIDTH  sprite ROM read address.
- rom_data  in  3  palette index; valid exactly one cycle after rom_addr.
- write_x, write_y  out  COOR_WIDTH each  pixel-write coordinate to the frame buffer.
- write_palette  out  3  palette index; 0 means no write.
- busy  out  1  command in progress.

Function
REQ-005 SHALL implement FSM states IDLE, DRAW, DRAIN.
REQ-006 In IDLE, cmd_ready SHALL be high iff frame_start is low; all other states SHALL hold cmd_ready low.
REQ-007 On acceptance, the block SHALL latch cmd_*; set col=0, row=0, rom_addr=cmd_base; and go to DRAW. If cmd_w==0 or cmd_h==0, it SHALL instead stay in IDLE and produce no writes.
REQ-008 In DRAW, each cycle SHALL issue one ROM read for (col,row) and then advance the counters.
- Advance rule: col increments; at col==w-1, col resets to 0 and row increments.
- rom_addr SHALL increment by 1 per cycle, a running address with no multiplier.
REQ-009 After the read for (w-1,h-1), the FSM SHALL go to DRAIN for exactly one cycle, then to IDLE.
REQ-010 The write pipeline SHALL be 1 cycle (ROM latency) plus 1 output register, so the write for a ROM read issued in cycle N appears in cycle N+2.
REQ-011 Write coordinates SHALL be write_x = x+col and write_y = y+row, with each sum computed at COOR_WIDTH+1 bits.
REQ-012 Clipping: if x+col >= FRAME_W or y+row >= FRAME_H, write_palette SHALL be 0 for that pixel. Coordinates SHALL never wrap.
REQ-013 rom_data==0 (transparent) SHALL produce write_palette 0.
REQ-014 When no write is pending, write_palette SHALL be 0; write_x and write_y SHALL hold their last values.
REQ-015 frame_start high in any state SHALL abort the command, return the FSM to IDLE next cycle, and force write_palette to 0 from the next cycle on, including pipeline contents.
REQ-016 busy SHALL be high in DRAW and DRAIN, and while any pipeline stage holds a valid pixel.
REQ-017 A new command SHALL be accepted in the cycle after DRAIN at the earliest, giving one idle cycle between commands.
REQ-018 Throughput in DRAW SHALL be one pixel per cycle, with no stalls.

Reset
REQ-019 rst SHALL take priority over frame_start and cmd_valid.
REQ-020 While rst is high, and after it is released, the block SHALL be in IDLE with cmd_ready=0, busy=0, write_palette=0, write_x=0, write_y=0, rom_addr=0, and all pipeline valid bits cleared.
REQ-021 cmd_ready SHALL first rise on the cycle after rst deasserts, subject to REQ-006.
REQ-022 rst mid-command SHALL discard the command and its pipeline; no further writes from it.

Structure
REQ-023 A shared package SHALL hold the FSM state enum, the FRAME_W/FRAME_H defaults, and the palette index width (3).
REQ-024 Sub-module blit_counter SHALL hold col/row/rom_addr stepping and the last-pixel flag; the FSM and write pipeline SHALL stay in the top module.

Verification
REQ-025 Command (x=10, y=20, w=2, h=2, base=100), ROM mem[100..103]=1,2,3,4 -> rom_addr 100,101,102,103 in consecutive cycles; writes (10,20,1), (11,20,2), (10,21,3), (11,21,4), the first 2 cycles after the first read; then busy falls and cmd_ready rises.
REQ-026 Command x=1279, w=3, h=1, all ROM data=5 -> exactly one write with palette 5 at x=1279; next two cycles palette 0.
REQ-027 ROM data pattern 0,7,0,7 on a 4x1 sprite -> palette 0,7,0,7; exactly two effective writes.
REQ-028 frame_start asserted in the 3rd DRAW cycle of a 16x16 sprite -> write_palette 0 from the next cycle; cmd_ready low until frame_start drops, then high.
REQ-029 Command with w=0, h=5 -> accepted, busy stays 0, no write ever non-zero; the next command is accepted in the following cycle.
REQ-030 rst pulsed mid-sprite -> all outputs at reset values; no stale write after rst release; a new command draws correctly.
